// File: rtl/thr_simd_pkg.sv
// Shared FSM encoding, default image geometry and the per-pixel compare rule
// for the SIMD threshold controller.
package thr_simd_pkg;

  localparam int DEF_WIDTH      = 64;
  localparam int DEF_HEIGHT     = 64;
  localparam int DEF_SIMD_WIDTH = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Strict unsigned compare: a pixel equal to the threshold maps to 8'h00.
  function automatic logic [7:0] thr_compare(input logic [7:0] pix, input logic [7:0] thr);
    if (pix > thr) begin
      thr_compare = 8'hFF;
    end else begin
      thr_compare = 8'h00;
    end
  endfunction

endpackage

// File: rtl/threshold_simd_lane.sv
// One pixel lane of the SIMD threshold datapath: 8-bit pixel against the
// latched 8-bit threshold, producing a binary 8'hFF / 8'h00 result.
module threshold_simd_lane
  import thr_simd_pkg::*;
(
  input  logic [7:0] pix_i,
  input  logic [7:0] thr_i,
  output logic [7:0] res_o
);

  assign res_o = thr_compare(pix_i, thr_i);

endmodule

// File: rtl/threshold_simd_ctrl.sv
// Frame-level SIMD threshold controller: read word, threshold every lane, write word.
// Optional per-frame hit counter enabled by THRESHOLD_SIMD_CTRL_STATS_EN.
module threshold_simd_ctrl
  import thr_simd_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int HEIGHT     = DEF_HEIGHT,
  parameter int SIMD_WIDTH = DEF_SIMD_WIDTH,
  parameter int AW         = $clog2(WIDTH * HEIGHT / SIMD_WIDTH)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    start_i,
  input  logic [7:0]              threshold_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    rd_req_o,
  output logic [AW-1:0]           rd_addr_o,
  input  logic                    rd_gnt_i,
  input  logic                    rd_valid_i,
  input  logic [8*SIMD_WIDTH-1:0] rd_data_i,
  output logic                    wr_req_o,
  output logic [AW-1:0]           wr_addr_o,
  output logic [8*SIMD_WIDTH-1:0] wr_data_o,
  input  logic                    wr_gnt_i
`ifdef THRESHOLD_SIMD_CTRL_STATS_EN
  ,
  output logic [$clog2(WIDTH*HEIGHT+1)-1:0] hit_count_o
`endif
);

  localparam int            DW       = 8 * SIMD_WIDTH;
  localparam int            WORDS    = WIDTH * HEIGHT / SIMD_WIDTH;
  localparam logic [AW-1:0] LAST_IDX = AW'(WORDS - 1);

  state_e          state_q, state_d;
  logic [AW-1:0]   index_q, index_d;
  logic [7:0]      thr_q, thr_d;
  logic [DW-1:0]   result_q, result_d;
  logic [DW-1:0]   lane_res_s;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            rd_req_q, rd_req_d;
  logic            wr_req_q, wr_req_d;

  for (genvar k = 0; k < SIMD_WIDTH; k++) begin : g_lane
    threshold_simd_lane u_lane (
      .pix_i (rd_data_i[8*k +: 8]),
      .thr_i (thr_q),
      .res_o (lane_res_s[8*k +: 8])
    );
  end

  // Next-state, word index, latched threshold and result capture.
  always_comb begin
    state_d  = state_q;
    index_d  = index_q;
    thr_d    = thr_q;
    result_d = result_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_READ;
          index_d = '0;
          thr_d   = threshold_i;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_READ: begin
        if (rd_gnt_i) begin
          state_d = ST_WAIT;
        end else begin
          state_d = ST_READ;
        end
      end
      ST_WAIT: begin
        if (rd_valid_i) begin
          result_d = lane_res_s;
          state_d  = ST_WRITE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WRITE: begin
        if (wr_gnt_i) begin
          if (index_q == LAST_IDX) begin
            state_d = ST_DONE;
          end else begin
            index_d = index_q + AW'(1);
            state_d = ST_READ;
          end
        end else begin
          state_d = ST_WRITE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Control outputs are decoded from the next state so they leave a flop.
  always_comb begin
    busy_d   = 1'b0;
    done_d   = 1'b0;
    rd_req_d = 1'b0;
    wr_req_d = 1'b0;
    case (state_d)
      ST_IDLE:  busy_d = 1'b0;
      ST_READ:  begin busy_d = 1'b1; rd_req_d = 1'b1; end
      ST_WAIT:  busy_d = 1'b1;
      ST_WRITE: begin busy_d = 1'b1; wr_req_d = 1'b1; end
      ST_DONE:  done_d = 1'b1;
      default:  busy_d = 1'b0;
    endcase
  end

  // State and datapath registers; reset abandons any frame in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      index_q  <= '0;
      thr_q    <= 8'h00;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rd_req_q <= 1'b0;
      wr_req_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      index_q  <= index_d;
      thr_q    <= thr_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      rd_req_q <= rd_req_d;
      wr_req_q <= wr_req_d;
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign rd_req_o  = rd_req_q;
  assign rd_addr_o = index_q;
  assign wr_req_o  = wr_req_q;
  assign wr_addr_o = index_q;
  assign wr_data_o = result_q;

`ifdef THRESHOLD_SIMD_CTRL_STATS_EN
  localparam int HCW = $clog2(WIDTH * HEIGHT + 1);

  logic [HCW-1:0] hit_q, hit_d;
  logic [HCW-1:0] word_hits_s;

  // Number of saturated lanes in the word currently offered for writing.
  always_comb begin
    word_hits_s = '0;
    for (int k = 0; k < SIMD_WIDTH; k++) begin
      if (result_q[8*k +: 8] == 8'hFF) begin
        word_hits_s = word_hits_s + HCW'(1);
      end else begin
        word_hits_s = word_hits_s;
      end
    end
  end

  // Counter clears on an accepted start and accumulates only on write grant.
  always_comb begin
    hit_d = hit_q;
    if ((state_q == ST_IDLE) && start_i) begin
      hit_d = '0;
    end else if ((state_q == ST_WRITE) && wr_gnt_i) begin
      hit_d = hit_q + word_hits_s;
    end else begin
      hit_d = hit_q;
    end
  end

  // Hit counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hit_q <= '0;
    end else begin
      hit_q <= hit_d;
    end
  end

  assign hit_count_o = hit_q;
`endif

endmodule

// File: tb/tb_threshold_simd_ctrl.sv
// Self-checking bench for threshold_simd_ctrl: a randomised memory responder
// driven against a per-pixel image model, with directed boundary frames.
module tb_threshold_simd_ctrl;

  localparam int WIDTH  = 64;
  localparam int HEIGHT = 64;
  localparam int SIMD   = 4;
  localparam int PIXELS = WIDTH * HEIGHT;
  localparam int WORDS  = PIXELS / SIMD;
  localparam int AW     = $clog2(WORDS);
  localparam int DW     = 8 * SIMD;
  localparam int HCW    = $clog2(PIXELS + 1);

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          start_i;
  logic [7:0]    threshold_i;
  logic          busy_o;
  logic          done_o;
  logic          rd_req_o;
  logic [AW-1:0] rd_addr_o;
  logic          rd_gnt_i;
  logic          rd_valid_i;
  logic [DW-1:0] rd_data_i;
  logic          wr_req_o;
  logic [AW-1:0] wr_addr_o;
  logic [DW-1:0] wr_data_o;
  logic          wr_gnt_i;
`ifdef THRESHOLD_SIMD_CTRL_STATS_EN
  logic [HCW-1:0] hit_count_o;
`endif

  int checks = 0;
  int errors = 0;
  logic [7:0] img [PIXELS];

  threshold_simd_ctrl dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .start_i     (start_i),
    .threshold_i (threshold_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .rd_req_o    (rd_req_o),
    .rd_addr_o   (rd_addr_o),
    .rd_gnt_i    (rd_gnt_i),
    .rd_valid_i  (rd_valid_i),
    .rd_data_i   (rd_data_i),
    .wr_req_o    (wr_req_o),
    .wr_addr_o   (wr_addr_o),
    .wr_data_o   (wr_data_o),
    .wr_gnt_i    (wr_gnt_i)
`ifdef THRESHOLD_SIMD_CTRL_STATS_EN
    ,
    .hit_count_o (hit_count_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] src_word(input int a);
    logic [DW-1:0] w;
    for (int k = 0; k < SIMD; k++) w[8*k +: 8] = img[a*SIMD + k];
    return w;
  endfunction

  function automatic logic [DW-1:0] exp_word(input int a, input logic [7:0] thr);
    logic [DW-1:0] w;
    for (int k = 0; k < SIMD; k++) w[8*k +: 8] = (img[a*SIMD + k] > thr) ? 8'hFF : 8'h00;
    return w;
  endfunction

  function automatic int count_hits(input logic [7:0] thr);
    int n = 0;
    for (int i = 0; i < PIXELS; i++) if (img[i] > thr) n++;
    return n;
  endfunction

  function automatic logic roll(input int stall_pct);
    if (stall_pct == 0) return 1'b1;
    return ($urandom_range(0, 99) >= stall_pct);
  endfunction

  task automatic fill_img(input int mode);
    for (int i = 0; i < PIXELS; i++) begin
      case (mode)
        1:       img[i] = 8'h00;
        2:       img[i] = 8'hFF;
        default: img[i] = 8'($urandom);
      endcase
    end
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_busy"},    64'(busy_o),    64'd0);
    chk({tag, "_done"},    64'(done_o),    64'd0);
    chk({tag, "_rd_req"},  64'(rd_req_o),  64'd0);
    chk({tag, "_wr_req"},  64'(wr_req_o),  64'd0);
    chk({tag, "_rd_addr"}, 64'(rd_addr_o), 64'd0);
    chk({tag, "_wr_addr"}, 64'(wr_addr_o), 64'd0);
    chk({tag, "_wr_data"}, 64'(wr_data_o), 64'd0);
`ifdef THRESHOLD_SIMD_CTRL_STATS_EN
    chk({tag, "_hits"},    64'(hit_count_o), 64'd0);
`endif
  endtask

  // One frame against the responder. stall_pct: chance (%) of withholding each
  // grant/valid; noise: stray start_i / rd_valid_i / threshold_i while busy;
  // abort_idx >= 0 pulses reset when the read of that word is requested.
  task automatic run_frame(input logic [7:0] thr, input int stall_pct, input bit noise,
                           input int abort_idx, input bit chk_lat,
                           input bit chk_first, input logic [DW-1:0] first_exp);
    int idx = 0;
    int cyc = 0;
    int pend_addr = 0;
    int hits_exp;
    bit fin = 1'b0;
    bit aborted = 1'b0;
    bit rd_pend = 1'b0;
    hits_exp = count_hits(thr);
    @(negedge clk_i);
    threshold_i = thr;
    start_i = 1'b1;
    while (!fin && cyc < 20000) begin
      @(posedge clk_i);
      cyc++;
      @(negedge clk_i);
      start_i     = noise ? ($urandom_range(0, 9) == 0) : 1'b0;
      threshold_i = noise ? 8'($urandom) : thr;
      chk("req_exclusive", 64'(rd_req_o & wr_req_o), 64'd0);
      if (done_o) begin
        fin = 1'b1;
        chk("busy_at_done", 64'(busy_o), 64'd0);
        chk("writes_at_done", 64'(idx), 64'(WORDS));
        if (chk_lat) chk("done_latency", 64'(cyc), 64'(3*WORDS + 1));
`ifdef THRESHOLD_SIMD_CTRL_STATS_EN
        chk("hits_at_done", 64'(hit_count_o), 64'(hits_exp));
`endif
        rd_gnt_i = 1'b0; rd_valid_i = 1'b0; wr_gnt_i = 1'b0;
      end else if (rd_req_o && abort_idx == idx) begin
        rst_ni = 1'b0;
        start_i = 1'b0; rd_gnt_i = 1'b0; rd_valid_i = 1'b0; wr_gnt_i = 1'b0;
        #1;
        check_quiet("abort_async");
        @(negedge clk_i);
        check_quiet("abort_held");
        rst_ni = 1'b1;
        fin = 1'b1;
        aborted = 1'b1;
      end else begin
        chk("busy_in_frame", 64'(busy_o), 64'd1);
        rd_data_i = DW'($urandom);
        if (rd_req_o) begin
          chk("rd_addr", 64'(rd_addr_o), 64'(idx));
          chk("rd_single_outstanding", 64'(rd_pend), 64'd0);
          rd_gnt_i = roll(stall_pct);
          if (rd_gnt_i) begin
            rd_pend = 1'b1;
            pend_addr = idx;
          end
          rd_valid_i = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        end else if (rd_pend && !wr_req_o) begin
          rd_gnt_i = 1'b0;
          rd_valid_i = roll(stall_pct);
          if (rd_valid_i) begin
            rd_data_i = src_word(pend_addr);
            rd_pend = 1'b0;
          end
        end else begin
          rd_gnt_i = 1'b0;
          rd_valid_i = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        if (wr_req_o) begin
          chk("wr_addr", 64'(wr_addr_o), 64'(idx));
          chk("wr_data", 64'(wr_data_o), 64'(exp_word(idx, thr)));
          if (chk_first && idx == 0) chk("wr_data_word0", 64'(wr_data_o), 64'(first_exp));
          wr_gnt_i = roll(stall_pct);
          if (wr_gnt_i) idx++;
        end else begin
          wr_gnt_i = 1'b0;
        end
      end
    end
    chk("frame_completed", 64'(fin), 64'd1);
    if (!aborted) begin
      // A start in the DONE cycle must not relaunch the controller.
      start_i = noise;
      @(negedge clk_i);
      start_i = 1'b0;
      chk("done_one_cycle", 64'(done_o), 64'd0);
      chk("idle_after_done", 64'(busy_o), 64'd0);
      chk("no_read_after_done", 64'(rd_req_o), 64'd0);
`ifdef THRESHOLD_SIMD_CTRL_STATS_EN
      chk("hits_hold", 64'(hit_count_o), 64'(hits_exp));
`endif
    end
  endtask

  initial begin
    rst_ni = 1'b0;
    start_i = 1'b0;
    threshold_i = 8'h00;
    rd_gnt_i = 1'b0;
    rd_valid_i = 1'b0;
    rd_data_i = '0;
    wr_gnt_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check_quiet("reset");
    rst_ni = 1'b1;
    @(negedge clk_i);
    check_quiet("post_reset");

    // Word 0 carries 32'h81_80_7F_FF at thr=128; zero-wait handshakes.
    fill_img(0);
    img[0] = 8'hFF; img[1] = 8'h7F; img[2] = 8'h80; img[3] = 8'h81;
    run_frame(8'd128, 0, 1'b0, -1, 1'b1, 1'b1, 32'hFF0000FF);

    // Random stalls with stray start/valid/threshold activity.
    fill_img(0);
    run_frame(8'($urandom), 40, 1'b1, -1, 1'b0, 1'b0, '0);

    // Reset mid-frame at word 500, then a clean restart from address 0.
    fill_img(0);
    run_frame(8'd100, 20, 1'b0, 500, 1'b0, 1'b0, '0);
    check_quiet("after_abort");
    run_frame(8'd100, 0, 1'b1, -1, 1'b1, 1'b0, '0);

    // Threshold extremes.
    fill_img(1);
    run_frame(8'd0, 10, 1'b0, -1, 1'b0, 1'b0, '0);
    fill_img(2);
    run_frame(8'd255, 0, 1'b0, -1, 1'b0, 1'b0, '0);
    run_frame(8'd254, 0, 1'b0, -1, 1'b0, 1'b0, '0);
`ifdef THRESHOLD_SIMD_CTRL_STATS_EN
    chk("hits_all_ff", 64'(hit_count_o), 64'(PIXELS));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/threshold_simd_ctrl.md
THRESHOLD_SIMD_CTRL -- requirements
Module: threshold_simd_ctrl

Interface
REQ-001 Parameters SHALL be: WIDTH, default 64, image columns in pixels.
REQ-002 Parameters SHALL be: HEIGHT, default 64, image rows in pixels.
REQ-003 Parameters SHALL be: SIMD_WIDTH, default 4, pixels per memory word; WIDTH % SIMD_WIDTH == 0.
REQ-004 Parameters SHALL be: AW, default $clog2(WIDTH*HEIGHT/SIMD_WIDTH), word-address width.
REQ-005 Ports SHALL be: clk_i  in  1  the single clock.
REQ-006 Ports SHALL be: rst_ni  in  1  asynchronous, active-low reset.
REQ-007 Ports SHALL be: start_i  in  1  pulse that launches one frame.
REQ-008 Ports SHALL be: threshold_i  in  8  compare level, sampled at start.
REQ-009 Ports SHALL be: busy_o  out  1  high from accepted start until done.
REQ-010 Ports SHALL be: done_o  out  1  one-cycle pulse at end of frame.
REQ-011 Ports SHALL be: rd_req_o, rd_addr_o  out  1, AW  source word request and address.
REQ-012 Ports SHALL be: rd_gnt_i  in  1  read request accepted.
REQ-013 Ports SHALL be: rd_valid_i, rd_data_i  in  1, 8*SIMD_WIDTH  read response; pixel k in bits [8k+7:8k].
REQ-014 Ports SHALL be: wr_req_o, wr_addr_o, wr_data_o  out  1, AW, 8*SIMD_WIDTH  result word write.
REQ-015 Ports SHALL be: wr_gnt_i  in  1  write accepted.

Function
REQ-016 FSM states SHALL be IDLE, READ, WAIT, WRITE, DONE.
REQ-017 IDLE->READ SHALL occur on start_i; threshold_i is latched and the word index is cleared to 0; start_i outside IDLE is ignored.
REQ-018 READ: rd_req_o=1 and rd_addr_o=index are held stable until rd_gnt_i, then the FSM goes to WAIT.
REQ-019 WAIT: on rd_valid_i, each lane computes out_k = (pix_k > thr) ? 8'hFF : 8'h00 (strict, unsigned); the result is registered, then WRITE.
REQ-020 WRITE: wr_req_o=1 with wr_addr_o=index and wr_data_o stable until wr_gnt_i.
REQ-021 On wr_gnt_i, if index == WIDTH*HEIGHT/SIMD_WIDTH-1 the FSM goes to DONE, else index+1 and READ.
REQ-022 DONE SHALL assert done_o for exactly one cycle and return to IDLE.
REQ-023 At most one read SHALL be outstanding; rd_valid_i outside WAIT is ignored.
REQ-024 Minimum per-word latency with zero-wait grant/valid SHALL be 3 cycles (READ, WAIT, WRITE).
REQ-025 The index counter SHALL never wrap within a frame; a start_i in the DONE cycle is ignored.

Reset
REQ-026 rst_ni low SHALL force IDLE asynchronously, including mid-frame, with index=0, latched threshold=0, result=0, and all outputs 0 (busy_o, done_o, rd_req_o, wr_req_o, addresses, wr_data_o); the aborted frame is not resumed.

Configuration
REQ-027 With THRESHOLD_SIMD_CTRL_STATS_EN defined, an extra output hit_count_o [$clog2(WIDTH*HEIGHT+1)-1:0] SHALL count pixels written as 8'hFF; it is cleared at accepted start and at reset, and holds after done. Without the macro, the port and the counter are absent.

Structure
REQ-028 Package thr_simd_pkg SHALL hold the FSM state enum and the default WIDTH/HEIGHT/SIMD_WIDTH constants.
REQ-029 The per-lane compare SHALL be a sub-module, threshold_simd_lane (8-bit pixel, 8-bit threshold -> 8-bit result), instantiated SIMD_WIDTH times.

Verification
REQ-030 Single-word frame (WIDTH=4, HEIGHT=1), thr=128, read data 32'h81_80_7F_FF -> wr_data_o=32'hFF_00_00_FF at addr 0, done_o pulse.
REQ-031 Full 64x64 frame, grants and valid tied high -> 1024 writes to addresses 0..1023 in order, done_o one cycle about 3072 cycles after start.
REQ-032 Random rd_gnt_i/wr_gnt_i stalls -> addresses and data are held stable while requests are pending, with no skipped or duplicated index.
REQ-033 rst_ni pulsed at index 500 -> all outputs 0 immediately; a new start_i then restarts at address 0.
REQ-034 Thresholds 0 and 255: all-0x00 image with thr=0 -> all 00; all-0xFF image with thr=255 -> all 00; all-0xFF image with thr=254 -> all FF (hit_count_o=4096 when STATS_EN).
REQ-035 start_i pulsed while busy, and rd_valid_i pulsed in READ -> both ignored, output image unchanged.
